lcd1602_bus_decoder: RTL and testbench
======================================

Name: lcd1602_bus_decoder

Overview:
- Receiving end of the HD44780-style 8-bit LCD1602 bus (rs, rw, enable, data) driven by the display controller.
- Latches each bus transfer on the falling edge of enable, decodes the instruction set, and maintains a shadow DDRAM (80 chars), a shadow CGRAM (64x5), the address counter and the display mode flags.
- Used as an on-chip display mirror for VGA/debug readout and as the checker model in controller testbenches.

Parameters:
SYNC_STAGES, 2, flops in the input synchronizer for lcd_enable, lcd_rs, lcd_rw and lcd_data (minimum 2).
CLEAR_CYCLES, 80, clk cycles of busy per clear; one DDRAM location is written with 0x20 per cycle. Fixed at 80.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
lcd_rs  in  1  register select: 0 = instruction, 1 = data
lcd_rw  in  1  1 = read cycle; ignored
lcd_enable  in  1  bus strobe; transfer latched on its falling edge
lcd_data  in  8  bus data
rd_addr  in  7  DDRAM read address in HD44780 space (0x00-0x27, 0x40-0x67)
rd_data  out  8  DDRAM char at rd_addr; 1-cycle latency
cg_rd_addr  in  6  CGRAM read address
cg_rd_data  out  5  CGRAM row at cg_rd_addr; 1-cycle latency
ac  out  7  address counter; in CGRAM mode {1'b0, cg_ac}
ac_is_cgram  out  1  1 = AC currently targets CGRAM
display_on, cursor_on, blink_on  out  1 each  D, C, B bits of display control
two_line  out  1  N bit of function set
entry_inc  out  1  I/D bit of entry mode
busy  out  1  clear sequence in progress
cmd_strobe  out  1  1-cycle pulse: instruction accepted
char_strobe  out  1  1-cycle pulse: data byte written
last_byte  out  8  byte of the last accepted transfer
protocol_err  out  1  1-cycle pulse: transfer dropped or address clamped

Behaviour:
- Reset state: FSM = CLEAR, busy = 1, clear pointer = 0, ac = 0, ac_is_cgram = 0, display_on = cursor_on = blink_on = 0, two_line = 0, entry_inc = 1, strobes = 0, protocol_err = 0, last_byte = 0, rd_data = 0x20, cg_rd_data = 0. CGRAM contents are undefined after reset.
- Input capture: all bus inputs pass through SYNC_STAGES flops. While synced enable = 1, a hold register captures {rs, rw, data} every cycle. A falling edge is synced enable 1 -> 0 between consecutive cycles. Outputs update and strobes pulse on the next clk, so raw enable fall to strobe is SYNC_STAGES + 1 cycles.
- FSM IDLE: accepts edges.
- FSM CLEAR: writes 0x20 to linear index 0..79, one per cycle. After 80 cycles it returns to IDLE and busy drops.
- Any edge seen while busy = 1, including the final CLEAR cycle, is dropped and pulses protocol_err. No other state changes.
- Edges with rw = 1 are ignored: no strobes and no error.
- Instruction decode (rs = 0), priority by highest set bit:
  - 0x01: clear. Enter CLEAR, ac = 0, DDRAM mode, entry_inc = 1.
  - 0x02/0x03: home. ac = 0, DDRAM mode.
  - 0x04-0x07: entry_inc = bit1. The shift bit is ignored.
  - 0x08-0x0F: display_on = bit2, cursor_on = bit1, blink_on = bit0.
  - 0x10-0x1F: if bit3 = 0, move AC one step (bit2 = 1 increments) using the data-write wrap rules. If bit3 = 1, no effect.
  - 0x20-0x3F: two_line = bit3.
  - 0x40-0x7F: cg_ac = data[5:0], CGRAM mode.
  - 0x80-0xFF: ac = data[6:0], DDRAM mode. Addresses 0x28-0x3F clamp to 0x40 and 0x68-0x7F clamp to 0x00; a clamp pulses protocol_err together with cmd_strobe.
  - Every accepted instruction pulses cmd_strobe and loads last_byte.
- Data write (rs = 1):
  - DDRAM mode: store the byte at the linear index. The index is ac for ac < 0x40, otherwise ac - 0x40 + 40.
  - CGRAM mode: store data[4:0] at cg_ac.
  - Then step AC per entry_inc. Pulse char_strobe and load last_byte.
- DDRAM AC wrap:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
  - CGRAM AC wraps modulo 64 in both directions.
- Readout: rd_data is registered from rd_addr, reading 0x20 for invalid addresses. During CLEAR it returns the current contents (partially cleared).
- Reset asserted mid-transfer or mid-clear restarts from the reset state immediately. A stale hold register never produces a strobe.

Test Plan:
- Release reset, idle for 85 cycles: busy = 1 for exactly 80 cycles. Then rd_data = 0x20 for rd_addr 0x00, 0x27, 0x40, 0x67 and also for invalid 0x30.
- Send 0x38, 0x0C, 0x06: two_line = 1, display_on = 1, cursor_on = 0, blink_on = 0, entry_inc = 1, three cmd_strobe pulses, last_byte = 0x06.
- Send 0x89, then rs = 1 "5": rd_addr 0x09 reads 0x35, ac = 0x0A, one char_strobe. Send 0xA7 + 'A' + 'B': 0x27 = 0x41, 0x40 = 0x42, ac = 0x41.
- Send 0x04 (decrement), 0x80, 'X': rd 0x00 = 0x58, ac = 0x67. Send 0xB0: ac = 0x40 and protocol_err pulses.
- Send 0x48, then 0x1F, 0x11: cg_rd_addr 8 = 0x1F, 9 = 0x11, ac_is_cgram = 1. Send 0x7F + two bytes: cg_ac wraps 0x3F -> 0x00 -> 0x01.
- Send 0x01, then 0xC0 within 10 cycles: second edge dropped with protocol_err, ac = 0. Assert reset mid-clear: busy stays 1 and the full 80 cycles restart. Edges with rw = 1 produce no strobes.

Source files
------------

// File: rtl/lcd1602_bus_decoder_if.sv
// HD44780-style 8-bit LCD1602 bus as seen between a display controller and the mirror.
interface lcd1602_bus_decoder_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_enable;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, lcd_rw, lcd_enable, lcd_data);
  modport slave  (input  lcd_rs, lcd_rw, lcd_enable, lcd_data);
endinterface

// File: rtl/lcd1602_bus_decoder.sv
// LCD1602 bus receiver: latches transfers on enable fall, decodes the instruction set
// and maintains shadow DDRAM/CGRAM, address counter and display mode flags.
//   state   | meaning
//   S_IDLE  | accepting bus transfers
//   S_CLEAR | busy, writing 0x20 to one DDRAM location per cycle
module lcd1602_bus_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd1602_bus_decoder_if.slave  bus,
  input  logic [6:0]            rd_addr,
  output logic [7:0]            rd_data,
  input  logic [5:0]            cg_rd_addr,
  output logic [4:0]            cg_rd_data,
  output logic [6:0]            ac,
  output logic                  ac_is_cgram,
  output logic                  display_on,
  output logic                  cursor_on,
  output logic                  blink_on,
  output logic                  two_line,
  output logic                  entry_inc,
  output logic                  busy,
  output logic                  cmd_strobe,
  output logic                  char_strobe,
  output logic [7:0]            last_byte,
  output logic                  protocol_err
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  logic [SYNC_STAGES-1:0]      en_sync_q, en_sync_d, rs_sync_q, rs_sync_d, rw_sync_q, rw_sync_d;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q, data_sync_d;
  logic        en_prev_q, en_prev_d;
  logic [9:0]  hold_q, hold_d;
  state_t      state_q, state_d;
  logic [6:0]  clr_ptr_q, clr_ptr_d, ac_q, ac_d;
  logic [5:0]  cg_ac_q, cg_ac_d;
  logic        cgram_q, cgram_d, display_on_q, display_on_d, cursor_on_q, cursor_on_d;
  logic        blink_on_q, blink_on_d, two_line_q, two_line_d, entry_inc_q, entry_inc_d;
  logic        busy_q, busy_d, cmd_strobe_q, cmd_strobe_d, char_strobe_q, char_strobe_d;
  logic        protocol_err_q, protocol_err_d;
  logic [7:0]  last_byte_q, last_byte_d, rd_data_q, rd_data_d;
  logic [4:0]  cg_rd_data_q, cg_rd_data_d;

  logic [7:0]  ddram [80];
  logic [4:0]  cgram [64];
  logic        dd_we, cg_we;
  logic [6:0]  dd_waddr;
  logic [7:0]  dd_wdata;
  logic [5:0]  cg_waddr;
  logic [4:0]  cg_wdata;

  logic        en_s, fall, h_rs, h_rw, rd_valid;
  logic [7:0]  h_data;
  logic [6:0]  set_addr;

  function automatic logic [6:0] lin_idx(input logic [6:0] a);
    return (a < 7'h40) ? a : a - 7'd24;
  endfunction

  function automatic logic [6:0] dd_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  assign en_sync_d   = {en_sync_q[SYNC_STAGES-2:0], bus.lcd_enable};
  assign rs_sync_d   = {rs_sync_q[SYNC_STAGES-2:0], bus.lcd_rs};
  assign rw_sync_d   = {rw_sync_q[SYNC_STAGES-2:0], bus.lcd_rw};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.lcd_data};
  assign en_s        = en_sync_q[SYNC_STAGES-1];
  assign en_prev_d   = en_s;
  assign hold_d      = en_s ? {rs_sync_q[SYNC_STAGES-1], rw_sync_q[SYNC_STAGES-1],
                               data_sync_q[SYNC_STAGES-1]} : hold_q;
  assign fall        = en_prev_q & ~en_s;
  assign h_rs        = hold_q[9];
  assign h_rw        = hold_q[8];
  assign h_data      = hold_q[7:0];
  assign set_addr    = h_data[6:0];
  assign rd_valid    = (rd_addr < 7'h28) || ((rd_addr >= 7'h40) && (rd_addr < 7'h68));

  always_comb begin
    state_d        = state_q;
    clr_ptr_d      = clr_ptr_q;
    ac_d           = ac_q;
    cg_ac_d        = cg_ac_q;
    cgram_d        = cgram_q;
    display_on_d   = display_on_q;
    cursor_on_d    = cursor_on_q;
    blink_on_d     = blink_on_q;
    two_line_d     = two_line_q;
    entry_inc_d    = entry_inc_q;
    busy_d         = busy_q;
    last_byte_d    = last_byte_q;
    cmd_strobe_d   = 1'b0;
    char_strobe_d  = 1'b0;
    protocol_err_d = 1'b0;
    dd_we          = 1'b0;
    dd_waddr       = clr_ptr_q;
    dd_wdata       = 8'h20;
    cg_we          = 1'b0;
    cg_waddr       = cg_ac_q;
    cg_wdata       = h_data[4:0];

    if (state_q == S_CLEAR) begin
      dd_we     = 1'b1;
      clr_ptr_d = clr_ptr_q + 7'd1;
      if (clr_ptr_q == 7'(CLEAR_CYCLES - 1)) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end

    if (fall && !h_rw) begin
      if (state_q != S_IDLE) begin
        protocol_err_d = 1'b1;
      end else if (h_rs) begin
        char_strobe_d = 1'b1;
        last_byte_d   = h_data;
        if (cgram_q) begin
          cg_we   = 1'b1;
          cg_ac_d = entry_inc_q ? cg_ac_q + 6'd1 : cg_ac_q - 6'd1;
        end else begin
          dd_we    = 1'b1;
          dd_waddr = lin_idx(ac_q);
          dd_wdata = h_data;
          ac_d     = dd_step(ac_q, entry_inc_q);
        end
      end else begin
        cmd_strobe_d = 1'b1;
        last_byte_d  = h_data;
        casez (h_data)
          8'b1???????: begin
            cgram_d = 1'b0;
            if (set_addr >= 7'h68) begin
              ac_d           = 7'h00;
              protocol_err_d = 1'b1;
            end else if (set_addr >= 7'h28 && set_addr < 7'h40) begin
              ac_d           = 7'h40;
              protocol_err_d = 1'b1;
            end else begin
              ac_d = set_addr;
            end
          end
          8'b01??????: begin
            cg_ac_d = h_data[5:0];
            cgram_d = 1'b1;
          end
          8'b001?????: two_line_d = h_data[3];
          8'b0001????: begin
            // Cursor move reuses the data-write wrap rules; display shift has no effect.
            if (!h_data[3]) begin
              if (cgram_q) cg_ac_d = h_data[2] ? cg_ac_q + 6'd1 : cg_ac_q - 6'd1;
              else         ac_d    = dd_step(ac_q, h_data[2]);
            end
          end
          8'b00001???: begin
            display_on_d = h_data[2];
            cursor_on_d  = h_data[1];
            blink_on_d   = h_data[0];
          end
          8'b000001??: entry_inc_d = h_data[1];
          8'b0000001?: begin
            ac_d    = 7'h00;
            cgram_d = 1'b0;
          end
          8'b00000001: begin
            state_d     = S_CLEAR;
            busy_d      = 1'b1;
            clr_ptr_d   = 7'd0;
            ac_d        = 7'h00;
            cgram_d     = 1'b0;
            entry_inc_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    rd_data_d    = rd_valid ? ddram[lin_idx(rd_addr)] : 8'h20;
    cg_rd_data_d = cgram[cg_rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sync_q      <= '0;
      rs_sync_q      <= '0;
      rw_sync_q      <= '0;
      data_sync_q    <= '0;
      en_prev_q      <= 1'b0;
      hold_q         <= '0;
      state_q        <= S_CLEAR;
      clr_ptr_q      <= 7'd0;
      ac_q           <= 7'h00;
      cg_ac_q        <= 6'h00;
      cgram_q        <= 1'b0;
      display_on_q   <= 1'b0;
      cursor_on_q    <= 1'b0;
      blink_on_q     <= 1'b0;
      two_line_q     <= 1'b0;
      entry_inc_q    <= 1'b1;
      busy_q         <= 1'b1;
      cmd_strobe_q   <= 1'b0;
      char_strobe_q  <= 1'b0;
      protocol_err_q <= 1'b0;
      last_byte_q    <= 8'h00;
      rd_data_q      <= 8'h20;
      cg_rd_data_q   <= 5'h00;
    end else begin
      en_sync_q      <= en_sync_d;
      rs_sync_q      <= rs_sync_d;
      rw_sync_q      <= rw_sync_d;
      data_sync_q    <= data_sync_d;
      en_prev_q      <= en_prev_d;
      hold_q         <= hold_d;
      state_q        <= state_d;
      clr_ptr_q      <= clr_ptr_d;
      ac_q           <= ac_d;
      cg_ac_q        <= cg_ac_d;
      cgram_q        <= cgram_d;
      display_on_q   <= display_on_d;
      cursor_on_q    <= cursor_on_d;
      blink_on_q     <= blink_on_d;
      two_line_q     <= two_line_d;
      entry_inc_q    <= entry_inc_d;
      busy_q         <= busy_d;
      cmd_strobe_q   <= cmd_strobe_d;
      char_strobe_q  <= char_strobe_d;
      protocol_err_q <= protocol_err_d;
      last_byte_q    <= last_byte_d;
      rd_data_q      <= rd_data_d;
      cg_rd_data_q   <= cg_rd_data_d;
    end
  end

  // Shadow memories carry no reset; DDRAM is scrubbed by the clear sequence instead.
  always_ff @(posedge clk) begin
    if (dd_we) ddram[dd_waddr] <= dd_wdata;
    if (cg_we) cgram[cg_waddr] <= cg_wdata;
  end

  assign ac           = cgram_q ? {1'b0, cg_ac_q} : ac_q;
  assign ac_is_cgram  = cgram_q;
  assign display_on   = display_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign two_line     = two_line_q;
  assign entry_inc    = entry_inc_q;
  assign busy         = busy_q;
  assign cmd_strobe   = cmd_strobe_q;
  assign char_strobe  = char_strobe_q;
  assign last_byte    = last_byte_q;
  assign protocol_err = protocol_err_q;
  assign rd_data      = rd_data_q;
  assign cg_rd_data   = cg_rd_data_q;
endmodule

// File: tb/tb_lcd1602_bus_decoder.sv
// Scoreboard bench for lcd1602_bus_decoder: directed bus transfers with hand-computed results.
module tb_lcd1602_bus_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [5:0] cg_rd_addr = '0;
  logic [4:0] cg_rd_data;
  logic [6:0] ac;
  logic       ac_is_cgram, display_on, cursor_on, blink_on, two_line, entry_inc, busy;
  logic       cmd_strobe, char_strobe, protocol_err;
  logic [7:0] last_byte;

  lcd1602_bus_decoder_if bus_if ();

  lcd1602_bus_decoder #(.SYNC_STAGES(2), .CLEAR_CYCLES(80)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .rd_addr(rd_addr), .rd_data(rd_data), .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data),
    .ac(ac), .ac_is_cgram(ac_is_cgram), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .entry_inc(entry_inc), .busy(busy),
    .cmd_strobe(cmd_strobe), .char_strobe(char_strobe), .last_byte(last_byte),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         cmd;
    bit         chr;
    bit         err;
    bit         chk_byte;
    logic [7:0] b;
  } exp_t;

  localparam int K_NONE = 0, K_CMD = 1, K_CHR = 2, K_DROP = 3, K_CLAMP = 4;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (cmd_strobe || char_strobe || protocol_err)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got cmd=%0b chr=%0b err=%0b, expected none",
                 cmd_strobe, char_strobe, protocol_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cmd_strobe !== e.cmd || char_strobe !== e.chr || protocol_err !== e.err ||
            (e.chk_byte && last_byte !== e.b)) begin
          n_fail++;
          $display("FAIL strobe: got cmd=%0b chr=%0b err=%0b byte=0x%0h, expected cmd=%0b chr=%0b err=%0b byte=0x%0h",
                   cmd_strobe, char_strobe, protocol_err, last_byte, e.cmd, e.chr, e.err, e.b);
        end
      end
    end
  end

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int kind);
    exp_t e;
    e.cmd      = (kind == K_CMD) || (kind == K_CLAMP);
    e.chr      = (kind == K_CHR);
    e.err      = (kind == K_DROP) || (kind == K_CLAMP);
    e.chk_byte = (kind != K_DROP);
    e.b        = d;
    if (kind != K_NONE) sb.push_back(e);
    @(negedge clk);
    bus_if.lcd_rs     = rs;
    bus_if.lcd_rw     = rw;
    bus_if.lcd_data   = d;
    bus_if.lcd_enable = 1'b1;
    repeat (4) @(negedge clk);
    bus_if.lcd_enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic cg_chk(input string name, input logic [5:0] a, input logic [4:0] exp);
    @(negedge clk);
    cg_rd_addr = a;
    @(negedge clk);
    chk(name, cg_rd_data, exp);
  endtask

  task automatic busy_run(input string name);
    int cnt = 0;
    for (int i = 0; i < 85; i++) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    chk(name, cnt, 80);
    chk({name, "_done"}, busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.lcd_rs = 0; bus_if.lcd_rw = 0; bus_if.lcd_enable = 0; bus_if.lcd_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_ac", ac, 0);
    chk("rst_cgram", ac_is_cgram, 0);
    chk("rst_flags", {display_on, cursor_on, blink_on, two_line}, 0);
    chk("rst_entry_inc", entry_inc, 1);
    chk("rst_last_byte", last_byte, 0);
    chk("rst_rd_data", rd_data, 8'h20);
    chk("rst_cg_rd_data", cg_rd_data, 0);
    reset = 1'b0;
    busy_run("busy_len");

    rd_chk("rd_00", 7'h00, 8'h20);
    rd_chk("rd_27", 7'h27, 8'h20);
    rd_chk("rd_40", 7'h40, 8'h20);
    rd_chk("rd_67", 7'h67, 8'h20);
    rd_chk("rd_invalid_30", 7'h30, 8'h20);

    xfer(0, 0, 8'h38, K_CMD);
    xfer(0, 0, 8'h0C, K_CMD);
    xfer(0, 0, 8'h06, K_CMD);
    chk("mode_flags", {two_line, display_on, cursor_on, blink_on, entry_inc}, 5'b11001);
    chk("mode_last_byte", last_byte, 8'h06);

    xfer(0, 0, 8'h89, K_CMD);
    xfer(1, 0, 8'h35, K_CHR);
    rd_chk("wr_09", 7'h09, 8'h35);
    chk("ac_0a", ac, 7'h0A);
    xfer(0, 0, 8'hA7, K_CMD);
    xfer(1, 0, 8'h41, K_CHR);
    xfer(1, 0, 8'h42, K_CHR);
    rd_chk("wr_27", 7'h27, 8'h41);
    rd_chk("wr_40", 7'h40, 8'h42);
    chk("ac_41", ac, 7'h41);

    xfer(0, 0, 8'h04, K_CMD);
    chk("entry_dec", entry_inc, 0);
    xfer(0, 0, 8'h80, K_CMD);
    xfer(1, 0, 8'h58, K_CHR);
    rd_chk("wr_00", 7'h00, 8'h58);
    chk("ac_dec_wrap_67", ac, 7'h67);
    xfer(0, 0, 8'hB0, K_CLAMP);
    chk("ac_clamp_40", ac, 7'h40);

    xfer(0, 0, 8'h06, K_CMD);
    xfer(0, 0, 8'h48, K_CMD);
    xfer(1, 0, 8'h1F, K_CHR);
    xfer(1, 0, 8'h11, K_CHR);
    cg_chk("cg_08", 6'd8, 5'h1F);
    cg_chk("cg_09", 6'd9, 5'h11);
    chk("ac_is_cgram", ac_is_cgram, 1);
    chk("cg_ac_0a", ac, 7'h0A);
    xfer(0, 0, 8'h7F, K_CMD);
    xfer(1, 0, 8'h0A, K_CHR);
    chk("cg_ac_wrap_00", ac, 7'h00);
    xfer(1, 0, 8'h15, K_CHR);
    chk("cg_ac_01", ac, 7'h01);
    cg_chk("cg_3f", 6'h3F, 5'h0A);
    cg_chk("cg_00", 6'h00, 5'h15);
    xfer(0, 0, 8'h14, K_CMD);
    chk("cg_shift_inc", ac, 7'h02);
    xfer(0, 0, 8'h18, K_CMD);
    chk("display_shift_noop", ac, 7'h02);
    xfer(0, 0, 8'h10, K_CMD);
    chk("cg_shift_dec", ac, 7'h01);

    xfer(0, 0, 8'h04, K_CMD);
    xfer(0, 1, 8'h01, K_NONE);
    chk("rw_no_clear", busy, 0);
    chk("rw_last_byte", last_byte, 8'h04);

    xfer(0, 0, 8'h01, K_CMD);
    xfer(0, 0, 8'hC0, K_DROP);
    chk("clear_busy", busy, 1);
    chk("clear_ac", ac, 7'h00);
    chk("clear_mode", {ac_is_cgram, entry_inc}, 2'b01);
    wait_idle();
    rd_chk("cleared_09", 7'h09, 8'h20);
    rd_chk("cleared_40", 7'h40, 8'h20);

    xfer(0, 0, 8'hC0, K_CMD);
    xfer(0, 0, 8'h10, K_CMD);
    chk("dd_dec_wrap_27", ac, 7'h27);
    xfer(0, 0, 8'h14, K_CMD);
    chk("dd_inc_wrap_40", ac, 7'h40);
    xfer(0, 0, 8'hE7, K_CMD);
    xfer(0, 0, 8'h14, K_CMD);
    chk("dd_inc_wrap_00", ac, 7'h00);
    xfer(0, 0, 8'hE7, K_CMD);
    xfer(0, 0, 8'hFF, K_CLAMP);
    chk("ac_clamp_00", ac, 7'h00);
    chk("last_byte_ff", last_byte, 8'hFF);

    xfer(0, 0, 8'h01, K_CMD);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_display", display_on, 0);
    chk("mid_rst_two_line", two_line, 0);
    reset = 1'b0;
    busy_run("busy_restart");

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
